// File: rtl/ppu_pkg.sv
// Shared state type, widths, int8 limits and the saturation helper used by the
// requantize/pack post-processing stage.
package ppu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   localparam int DATA_BITS = 32;
   localparam int OUT_BITS  = 8;
   localparam int PACK      = DATA_BITS / OUT_BITS;

   localparam int INT8_MIN = -128;
   localparam int INT8_MAX = 127;

   localparam logic [7:0] UINT8_BIAS = 8'h80;

   // Clamp a wide signed value into the int8 range.
   function automatic logic [7:0] sat8(input logic signed [33:0] x);
      logic [7:0] y;
      if (x > 34'(INT8_MAX)) begin
         y = 8'h7F;
      end else if (x < 34'(INT8_MIN)) begin
         y = 8'h80;
      end else begin
         y = x[7:0];
      end
      return y;
   endfunction

endpackage

// File: rtl/ppu_requant_lane.sv
// Two-stage requantization pipeline: rounding arithmetic shift, then zero-point add,
// optional ReLU and int8 saturation into the biased uint8 format (PPU_SAT_CNT_EN adds a saturation flag).
module ppu_requant_lane
   import ppu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 valid_i,
   input  logic                 last_i,
   input  logic [DATA_BITS-1:0] psum_i,
   input  logic [4:0]           shift_i,
   input  logic [7:0]           zp_i,
   input  logic                 relu_i,
   output logic                 s1_valid_o,
   output logic                 valid_o,
   output logic                 last_o,
   output logic [OUT_BITS-1:0]  byte_o
`ifdef PPU_SAT_CNT_EN
   ,
   output logic                 sat_o
`endif
);

   logic signed [32:0] ext;
   logic        [32:0] rnd;
   logic signed [32:0] sum33;
   logic signed [32:0] r_d;

   logic               s1_valid_q;
   logic               s1_last_q;
   logic signed [32:0] s1_r_q;

   logic signed [33:0] sum34;
   logic signed [7:0]  y8;
   logic        [7:0]  byte_d;

   logic               s2_valid_q;
   logic               s2_last_q;
   logic        [7:0]  s2_byte_q;

   // 33-bit math keeps the largest psum plus its rounding constant from wrapping.
   always_comb begin
      ext = {psum_i[DATA_BITS-1], psum_i};
      rnd = '0;
      if (shift_i != 5'd0) begin
         rnd = 33'd1 << (shift_i - 5'd1);
      end
      sum33 = ext + rnd;
      r_d   = sum33 >>> shift_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_r_q     <= '0;
      end else if (!stall_i) begin
         s1_valid_q <= valid_i;
         s1_last_q  <= last_i;
         s1_r_q     <= r_d;
      end
   end

   // ReLU clamps at the zero point, which is the requantized image of real zero.
   always_comb begin
      sum34 = {s1_r_q[32], s1_r_q} + {{26{zp_i[7]}}, zp_i};
      y8    = sat8(sum34);
      if (relu_i && (y8 < $signed(zp_i))) begin
         y8 = zp_i;
      end
      byte_d = y8 ^ UINT8_BIAS;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_byte_q  <= '0;
      end else if (!stall_i) begin
         s2_valid_q <= s1_valid_q;
         s2_last_q  <= s1_last_q;
         s2_byte_q  <= byte_d;
      end
   end

`ifdef PPU_SAT_CNT_EN
   logic sat_d;
   logic s2_sat_q;

   always_comb begin
      sat_d = (sum34 > 34'(INT8_MAX)) || (sum34 < 34'(INT8_MIN));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_sat_q <= 1'b0;
      end else if (!stall_i) begin
         s2_sat_q <= sat_d;
      end
   end

   assign sat_o = s2_sat_q;
`endif

   assign s1_valid_o = s1_valid_q;
   assign valid_o    = s2_valid_q;
   assign last_o     = s2_last_q;
   assign byte_o     = s2_byte_q;

endmodule

// File: rtl/ppu_requant_pack.sv
// PPU post-processing top: tile FSM, input counter and 4:1 byte packing around the requant lane.
// Optional saturation counter port sat_cnt is built when PPU_SAT_CNT_EN is defined.
module ppu_requant_pack
   import ppu_pkg::*;
#(
   parameter int LEN_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_en,
   input  logic [4:0]           cfg_shift,
   input  logic [7:0]           cfg_zero_point,
   input  logic                 cfg_relu,
   input  logic [LEN_BITS-1:0]  cfg_len,
   input  logic [DATA_BITS-1:0] psum_in,
   input  logic                 psum_valid,
   output logic                 psum_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy
`ifdef PPU_SAT_CNT_EN
   ,
   output logic [15:0]          sat_cnt
`endif
);

   state_e state_q, state_d;

   logic [4:0]          shift_q;
   logic [7:0]          zp_q;
   logic                relu_q;
   logic [LEN_BITS-1:0] len_q;
   logic [LEN_BITS-1:0] in_cnt_q;

   logic start;
   logic stall;
   logic in_fire;
   logic in_last;
   logic pipe_empty;

   logic                s1_valid;
   logic                s2_valid;
   logic                s2_last;
   logic [OUT_BITS-1:0] s2_byte;

   logic [DATA_BITS-1:0] pack_q, pack_d;
   logic [1:0]           lane_q, lane_d;
   logic                 pend_q, pend_d;
   logic                 pend_last_q, pend_last_d;
   logic [DATA_BITS-1:0] out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;

   assign start      = (state_q == IDLE) && cfg_en && (cfg_len != '0);
   assign stall      = out_valid_q && !out_ready;
   assign in_fire    = psum_valid && psum_ready;
   assign in_last    = (in_cnt_q == (len_q - LEN_BITS'(1)));
   assign pipe_empty = !s1_valid && !s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FLUSH also exits when nothing is left to emit, covering a tile whose last word already left.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if ((in_cnt_q == len_q) && pipe_empty) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if ((out_valid_q && out_ready && out_last_q) || (!pend_q && !out_valid_q)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != IDLE);
      psum_ready = (state_q == RUN) && (in_cnt_q != len_q) && !stall;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q  <= '0;
         zp_q     <= '0;
         relu_q   <= 1'b0;
         len_q    <= '0;
         in_cnt_q <= '0;
      end else if (start) begin
         shift_q  <= cfg_shift;
         zp_q     <= cfg_zero_point;
         relu_q   <= cfg_relu;
         len_q    <= cfg_len;
         in_cnt_q <= '0;
      end else if (in_fire) begin
         in_cnt_q <= in_cnt_q + LEN_BITS'(1);
      end
   end

   ppu_requant_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .stall_i    (stall),
      .valid_i    (in_fire),
      .last_i     (in_last),
      .psum_i     (psum_in),
      .shift_i    (shift_q),
      .zp_i       (zp_q),
      .relu_i     (relu_q),
      .s1_valid_o (s1_valid),
      .valid_o    (s2_valid),
      .last_o     (s2_last),
      .byte_o     (s2_byte)
`ifdef PPU_SAT_CNT_EN
      ,
      .sat_o      (s2_sat)
`endif
   );

   // A completed pack word moves to the output register the cycle after it fills,
   // while the next incoming byte already starts a fresh, zeroed word.
   always_comb begin
      pack_d      = pack_q;
      lane_d      = lane_q;
      pend_d      = pend_q;
      pend_last_d = pend_last_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      if (!stall) begin
         if (pend_q) begin
            out_data_d  = pack_q;
            out_valid_d = 1'b1;
            out_last_d  = pend_last_q;
         end else if (out_valid_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
         pack_d      = pend_q ? '0 : pack_q;
         pend_d      = 1'b0;
         pend_last_d = 1'b0;
         if (s2_valid) begin
            pack_d[lane_q*OUT_BITS +: OUT_BITS] = s2_byte;
            if ((lane_q == 2'(PACK-1)) || s2_last) begin
               pend_d      = 1'b1;
               pend_last_d = s2_last;
               lane_d      = 2'd0;
            end else begin
               lane_d = lane_q + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pack_q      <= '0;
         lane_q      <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         pack_q      <= pack_d;
         lane_q      <= start ? 2'd0 : lane_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

`ifdef PPU_SAT_CNT_EN
   logic [15:0] sat_cnt_q;

   // Counts only range clamps; ReLU clamping is deliberately not included.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_cnt_q <= '0;
      end else if (start) begin
         sat_cnt_q <= '0;
      end else if (s2_valid && !stall && s2_sat && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_q <= sat_cnt_q + 16'd1;
      end
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_ppu_requant_pack.sv
// Directed bench for ppu_requant_pack: hand-computed packed words for saturation, rounding,
// ReLU, partial words, backpressure, mid-tile reset and zero-length config (sat_cnt under PPU_SAT_CNT_EN).
module tb_ppu_requant_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_en;
   logic [4:0]  cfg_shift;
   logic [7:0]  cfg_zero_point;
   logic        cfg_relu;
   logic [15:0] cfg_len;
   logic [31:0] psum_in;
   logic        psum_valid;
   logic        psum_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
`ifdef PPU_SAT_CNT_EN
   logic [15:0] sat_cnt;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   logic [31:0] psumVec [16];
   logic [31:0] gotData [8];
   logic        gotLast [8];
   int          nWords;
   int          stallSeen;
   int          stallBad;
   logic        timedOut;

   always #5 clk = ~clk;

   ppu_requant_pack dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_en         (cfg_en),
      .cfg_shift      (cfg_shift),
      .cfg_zero_point (cfg_zero_point),
      .cfg_relu       (cfg_relu),
      .cfg_len        (cfg_len),
      .psum_in        (psum_in),
      .psum_valid     (psum_valid),
      .psum_ready     (psum_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .busy           (busy)
`ifdef PPU_SAT_CNT_EN
      ,
      .sat_cnt        (sat_cnt)
`endif
   );

   // Inputs change on the falling edge; outputs are sampled 1ns later, well away from posedge.
   task automatic runTile(input logic [4:0] sh, input logic [7:0] zp, input logic rl,
                          input logic [15:0] n, input int stallFrom, input int stallTo);
      int sent = 0;
      int cyc = 0;
      logic [31:0] heldData = '0;
      logic holding = 1'b0;
      nWords = 0;
      stallSeen = 0;
      stallBad = 0;
      timedOut = 1'b0;
      @(negedge clk);
      cfg_shift = sh;
      cfg_zero_point = zp;
      cfg_relu = rl;
      cfg_len = n;
      cfg_en = 1'b1;
      @(negedge clk);
      cfg_en = 1'b0;
      while (busy && cyc < 300) begin
         psum_valid = (sent < int'(n));
         psum_in = (sent < 16) ? psumVec[sent] : 32'd0;
         out_ready = !(cyc >= stallFrom && cyc < stallTo);
         #1;
         if (holding && (!out_valid || out_data !== heldData)) stallBad++;
         holding = out_valid && !out_ready;
         if (holding) begin
            heldData = out_data;
            stallSeen++;
            if (psum_ready) stallBad++;
         end
         if (psum_valid && psum_ready) sent++;
         if (out_valid && out_ready && nWords < 8) begin
            gotData[nWords] = out_data;
            gotLast[nWords] = out_last;
            nWords++;
         end
         @(negedge clk);
         cyc++;
      end
      psum_valid = 1'b0;
      out_ready = 1'b1;
      timedOut = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_en = 1'b0;
      cfg_shift = '0;
      cfg_zero_point = '0;
      cfg_relu = 1'b0;
      cfg_len = '0;
      psum_in = '0;
      psum_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      testsRun++; if (psum_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_psum_ready: got %b expected 0", psum_ready); end
      testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      testsRun++; if (out_last !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
      testsRun++; if (out_data !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_out_data: got %h expected 00000000", out_data); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_saturation();
      psumVec[0] = 32'd1;
      psumVec[1] = -32'sd1;
      psumVec[2] = 32'd127;
      psumVec[3] = 32'd128;
      runTile(5'd0, 8'd0, 1'b0, 16'd4, 1000, 1000);
      testsRun++; if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL sat_timeout: busy still %b expected 0", timedOut); end
      testsRun++; if (nWords !== 1) begin testsFailed++; $display("[TB] FAIL sat_words: got %0d expected 1", nWords); end
      testsRun++; if (gotData[0] !== 32'hFFFF7F81) begin testsFailed++; $display("[TB] FAIL sat_word: got %h expected FFFF7F81", gotData[0]); end
      testsRun++; if (gotLast[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat_last: got %b expected 1", gotLast[0]); end
`ifdef PPU_SAT_CNT_EN
      testsRun++; if (sat_cnt !== 16'd1) begin testsFailed++; $display("[TB] FAIL sat_cnt: got %0d expected 1", sat_cnt); end
`endif
   endtask

   task automatic test_rounding();
      psumVec[0] = 32'd5;
      psumVec[1] = 32'd6;
      psumVec[2] = -32'sd6;
      psumVec[3] = -32'sd7;
      runTile(5'd2, 8'd0, 1'b0, 16'd4, 1000, 1000);
      testsRun++; if (nWords !== 1) begin testsFailed++; $display("[TB] FAIL round_words: got %0d expected 1", nWords); end
      testsRun++; if (gotData[0] !== 32'h7E7F8281) begin testsFailed++; $display("[TB] FAIL round_word: got %h expected 7E7F8281", gotData[0]); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL round_busy: got %b expected 0", busy); end
   endtask

   task automatic test_relu();
      psumVec[0] = -32'sd50;
      psumVec[1] = 32'd5;
      psumVec[2] = 32'd200;
      psumVec[3] = 32'd0;
      runTile(5'd0, 8'd10, 1'b1, 16'd4, 1000, 1000);
      testsRun++; if (nWords !== 1) begin testsFailed++; $display("[TB] FAIL relu_words: got %0d expected 1", nWords); end
      testsRun++; if (gotData[0] !== 32'h8AFF8F8A) begin testsFailed++; $display("[TB] FAIL relu_word: got %h expected 8AFF8F8A", gotData[0]); end
      testsRun++; if (gotLast[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL relu_last: got %b expected 1", gotLast[0]); end
   endtask

   task automatic test_partial();
      for (int i = 0; i < 6; i++) psumVec[i] = 32'(i);
      runTile(5'd0, 8'd0, 1'b0, 16'd6, 1000, 1000);
      testsRun++; if (nWords !== 2) begin testsFailed++; $display("[TB] FAIL part_words: got %0d expected 2", nWords); end
      testsRun++; if (gotData[0] !== 32'h83828180) begin testsFailed++; $display("[TB] FAIL part_word0: got %h expected 83828180", gotData[0]); end
      testsRun++; if (gotLast[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL part_last0: got %b expected 0", gotLast[0]); end
      testsRun++; if (gotData[1] !== 32'h00008584) begin testsFailed++; $display("[TB] FAIL part_word1: got %h expected 00008584", gotData[1]); end
      testsRun++; if (gotLast[1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL part_last1: got %b expected 1", gotLast[1]); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL part_busy: got %b expected 0", busy); end
   endtask

   task automatic test_backpressure();
      logic [31:0] expWord [3];
      expWord[0] = 32'h83828180;
      expWord[1] = 32'h87868584;
      expWord[2] = 32'h8B8A8988;
      for (int i = 0; i < 12; i++) psumVec[i] = 32'(i);
      runTile(5'd0, 8'd0, 1'b0, 16'd12, 5, 15);
      testsRun++; if (nWords !== 3) begin testsFailed++; $display("[TB] FAIL bp_words: got %0d expected 3", nWords); end
      testsRun++; if (stallSeen < 5) begin testsFailed++; $display("[TB] FAIL bp_stall_seen: got %0d stalled cycles expected at least 5", stallSeen); end
      testsRun++; if (stallBad !== 0) begin testsFailed++; $display("[TB] FAIL bp_stall_rules: got %0d violations expected 0", stallBad); end
      for (int i = 0; i < 3; i++) begin
         testsRun++; if (gotData[i] !== expWord[i]) begin testsFailed++; $display("[TB] FAIL bp_word%0d: got %h expected %h", i, gotData[i], expWord[i]); end
         testsRun++; if (gotLast[i] !== (i == 2)) begin testsFailed++; $display("[TB] FAIL bp_last%0d: got %b expected %b", i, gotLast[i], (i == 2)); end
      end
   endtask

   task automatic test_reset_mid_run();
      int validSeen = 0;
      @(negedge clk);
      cfg_shift = 5'd0;
      cfg_zero_point = 8'd0;
      cfg_relu = 1'b0;
      cfg_len = 16'd8;
      cfg_en = 1'b1;
      @(negedge clk);
      cfg_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         psum_in = 32'(i);
         psum_valid = 1'b1;
         @(negedge clk);
      end
      psum_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      testsRun++; if (psum_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_psum_ready: got %b expected 0", psum_ready); end
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) validSeen++;
      end
      testsRun++; if (validSeen !== 0) begin testsFailed++; $display("[TB] FAIL midrst_no_output: got %0d valid cycles expected 0", validSeen); end
   endtask

   task automatic test_cfg_len_zero();
      @(negedge clk);
      cfg_len = 16'd0;
      cfg_en = 1'b1;
      @(negedge clk);
      cfg_en = 1'b0;
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL len0_busy: got %b expected 0", busy); end
      @(negedge clk);
      testsRun++; if (psum_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL len0_psum_ready: got %b expected 0", psum_ready); end
   endtask

   initial begin
      test_reset();
      test_saturation();
      test_rounding();
      test_relu();
      test_partial();
      test_backpressure();
      test_reset_mid_run();
      test_rounding();
      test_cfg_len_zero();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
